// File: rtl/alu_mul_seq.sv
// alu_mul_seq: forms an unsigned 2*WIDTH-bit product by running the shared ALU
// through WIDTH shift-and-add steps, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; product holds
// RUN   | one shift-and-add step per cycle through the external ALU
// DONE  | product final; done pulses for this one cycle
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               kill,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_z,
    input  logic               alu_cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_c;
    logic [WIDTH-1:0] w_s;

    assign w_accept = (r_state == IDLE) && start && !kill;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        alu_op      = OP_AND;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                alu_op = OP_ADD;
                if (kill)        w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // When the multiplier bit is 0 the partial sum is just hi; the add result is skipped.
    always_comb begin
        if (r_lo[0]) begin
            {w_c, w_s} = {alu_cout, alu_z};
        end else begin
            {w_c, w_s} = {1'b0, r_hi};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
        end else if ((r_state == RUN) && !kill) begin
            r_hi    <= {w_c, w_s[WIDTH-1:1]};
            r_lo    <= {w_s[0], r_lo[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign product = {r_hi, r_lo};
    assign alu_a   = r_hi;
    assign alu_b   = r_mcand;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: drives alu_mul_seq with directed and random operands against
// a behavioural ALU and a plain-arithmetic product model.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;
    logic        alu_cout;

    int n_checks;
    int n_fail;

    alu_mul_seq #(.WIDTH(32)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .kill     (kill),
        .a        (a_in),
        .b        (b_in),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_z    (alu_z),
        .alu_cout (alu_cout)
    );

    // Behavioural ALU adder.
    assign {alu_cout, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge. kill_at/rst_at/restart_at name the RUN cycle
    // (1 = first cycle after the start edge) at which that event is applied; 0 = never.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input int kill_at, input int rst_at, input int restart_at,
                          input bit start_on_done);
        logic [63:0] exp_p;
        int busy_cycles;
        int op_err;
        int done_k;
        bit fin;
        bit aborted;
        exp_p       = 64'(ta) * 64'(tb);
        busy_cycles = 0;
        op_err      = 0;
        done_k      = 0;
        fin         = 0;
        aborted     = 0;
        a_in  = ta;
        b_in  = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            if (done) begin
                done_k = k;
                fin    = 1;
            end else begin
                if (busy) busy_cycles++;
                if (!busy || alu_op !== 3'b010 || alu_b !== ta || alu_a !== product[63:32])
                    op_err++;
                if (k == kill_at) kill = 1'b1;
                if (k == rst_at) rst_n = 1'b0;
                if (k == restart_at) begin
                    start = 1'b1;
                    a_in  = 32'd1;
                    b_in  = 32'd1;
                end
                @(negedge clk);
                start = 1'b0;
                if (k == kill_at) begin
                    kill = 1'b0;
                    chk("kill_busy", 64'(busy), 64'd0);
                    chk("kill_no_done", 64'(done), 64'd0);
                    @(negedge clk);
                    chk("kill_no_done_later", 64'(done), 64'd0);
                    aborted = 1;
                    fin     = 1;
                end
                if (k == rst_at) begin
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_done", 64'(done), 64'd0);
                    chk("rst_product", product, 64'd0);
                    chk("rst_alu_op", 64'(alu_op), 64'd0);
                    rst_n   = 1'b1;
                    @(negedge clk);
                    aborted = 1;
                    fin     = 1;
                end
            end
        end
        if (!aborted) begin
            chk("done_latency", 64'(done_k), 64'd33);
            chk("busy_cycles", 64'(busy_cycles), 64'd32);
            chk("run_signals", 64'(op_err), 64'd0);
            chk("product", product, exp_p);
            chk("alu_op_done", 64'(alu_op), 64'd0);
            chk("busy_in_done", 64'(busy), 64'd0);
            if (start_on_done) begin
                start = 1'b1;
                a_in  = 32'hDEAD_BEEF;
                b_in  = 32'd3;
            end
            @(negedge clk);
            chk("done_pulse", 64'(done), 64'd0);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("product_hold", product, exp_p);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        kill     = 1'b0;
        a_in     = 32'd0;
        b_in     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_alu_op", 64'(alu_op), 64'd0);
        chk("reset_alu_b", 64'(alu_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // kill beats start in IDLE
        start = 1'b1;
        kill  = 1'b1;
        a_in  = 32'd5;
        b_in  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_over_start_busy", 64'(busy), 64'd0);
        chk("kill_over_start_product", product, 64'd0);

        run_op(32'd3, 32'd5, 0, 0, 0, 0);
        chk("basic_literal", product, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("carry_literal", product, 64'hFFFF_FFFE_0000_0001);

        // zero product, start held from the done cycle: ignored in DONE, accepted next
        run_op(32'd0, 32'h1234_5678, 0, 0, 0, 1);
        run_op(32'h8000_0000, 32'd2, 0, 0, 0, 0);
        chk("b2b_literal", product, 64'h1_0000_0000);

        run_op(32'd7, 32'd9, 0, 0, 10, 0);
        chk("start_busy_literal", product, 64'd63);

        run_op(32'd11, 32'd13, 5, 0, 0, 0);
        run_op(32'd6, 32'd7, 0, 0, 0, 0);
        chk("after_kill_literal", product, 64'd42);

        run_op(32'hABCD_0123, 32'h0F0F_F0F0, 0, 20, 0, 0);
        run_op(32'd100, 32'd1000, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h0000_0001;
                default: ;
            endcase
            run_op(ra, rb, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier controller that sequences the shared 32-bit ALU through 32 shift-and-add steps.
- Each step uses ALU add (op 3'b010) and the adder carry-out.
- Sits beside the ALU in the CPU datapath. The ALU stays combinational and external; this block drives its operand and op inputs, then captures its result.
- Start/busy/done handshake toward the issuing stage.

Parameters:
- WIDTH, 32, operand width; equals the ALU width. Product is 2*WIDTH bits. Step counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- kill  input  1  synchronous abort of the current operation.
- a  input  WIDTH  multiplicand, captured on accepted start.
- b  input  WIDTH  multiplier, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  2*WIDTH  result register {hi, lo}; holds its value until the next accepted start.
- alu_a  output  WIDTH  ALU operand A; always equals hi.
- alu_b  output  WIDTH  ALU operand B; always equals the captured multiplicand.
- alu_op  output  3  3'b010 (add) in RUN, 3'b000 (and) otherwise.
- alu_z  input  WIDTH  combinational ALU result, alu_a+alu_b during RUN.
- alu_cout  input  1  adder carry-out for the same add.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, product=0, multiplicand reg=0, cnt=0. Reset overrides start and kill, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE, start=1 (and kill=0):
  - mcand<=a; hi<=0; lo<=b; cnt<=0; go RUN.
  - done is low in IDLE.
- IDLE, start=0: remain in IDLE; product holds.
- RUN, one step per cycle:
  - If lo[0]=1: {c,s}={alu_cout,alu_z}. Else: {c,s}={0,hi}.
  - {hi,lo}<={c,s,lo}>>1, i.e. hi<={c,s[WIDTH-1:1]} and lo<={s[0],lo[WIDTH-1:1]}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, the step is the last one; go DONE.
- DONE: done=1 for exactly this one cycle, busy=0, product final; next state IDLE unconditionally. start in DONE is ignored.
- Latency: start accepted at edge E0; steps at E1..E32 (WIDTH=32); done=1 during the cycle after E32. Fixed 32 RUN cycles with no early termination. Next start is accepted the cycle after done.
- start while busy or in DONE: ignored, no queueing.
- kill=1 in RUN: go IDLE at the next edge. No done pulse. product holds the partial value and is undefined for use. kill in IDLE/DONE has no effect; in DONE the done pulse still occurs.
- kill and start both high in IDLE: kill wins, start is not accepted.
- busy is registered: busy=(state==RUN).
- alu_op toggles only on state changes; alu_z/alu_cout are consumed only in RUN.
- Arithmetic: unsigned, exact 2*WIDTH-bit product. No overflow is possible; carry is absorbed into hi via the shift.

Test Plan:
- Bench models the ALU as a behavioural adder: alu_z=alu_a+alu_b, with alu_cout.
- Basic: a=3, b=5, start pulse -> busy for 32 cycles, done one cycle later, product=64'h0000_0000_0000_000F, alu_op=010 only while busy.
- Carry path: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 exactly 33 cycles after the start edge.
- Zero and back-to-back:
  - a=0, b=32'h1234_5678 -> product=0.
  - Then start asserted in the same cycle as done -> ignored.
  - start the cycle after done with a=32'h8000_0000, b=2 -> product=64'h1_0000_0000.
- Start during busy: a=7, b=9 started; at step 10 assert start with a=1, b=1 -> ignored, product=63, single done pulse.
- Abort/reset:
  - kill at step 5 -> busy=0 next cycle, no done; new start a=6, b=7 -> product=42.
  - rst_n=0 at step 20 -> busy=0, done=0, product=0 the following cycle.
